// File: rtl/gather_vc_allocator.sv
// ----------------------------------------------------------------------------
// gather_vc_allocator
//   Packet-level virtual-channel allocator that drives the select inputs of a
//   5x5 gather crossbar. Each output VC runs its own round-robin arbiter over
//   the input VCs whose routed request targets it. A winner stays locked to
//   that output until its tail flit is accepted by the crossbar.
//
// Ports
//   clk              : clock, rising edge
//   rstn             : asynchronous active-low reset
//   req_vc0..req_vc4 : per input VC, routed target output VC (one-hot; if more
//                      than one bit is set, the lowest set bit is used)
//   valid_in         : flit valid per input VC
//   tail_in          : flit on input VC i is a packet tail
//   xbar_ready       : crossbar ready toward input VCs (fire = valid & ready)
//   selVCfromVC0..4  : bit j set => input VC i currently owns output VC j
//   out_locked       : bit j set => output VC j currently owned
// ----------------------------------------------------------------------------
module gather_vc_allocator #(
    parameter int NUM_VC  = 5,
    parameter int RR_INIT = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] req_vc0,
    input  logic [4:0] req_vc1,
    input  logic [4:0] req_vc2,
    input  logic [4:0] req_vc3,
    input  logic [4:0] req_vc4,
    input  logic [4:0] valid_in,
    input  logic [4:0] tail_in,
    input  logic [4:0] xbar_ready,
    output logic [4:0] selVCfromVC0,
    output logic [4:0] selVCfromVC1,
    output logic [4:0] selVCfromVC2,
    output logic [4:0] selVCfromVC3,
    output logic [4:0] selVCfromVC4,
    output logic [4:0] out_locked
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Per output VC j: FSM state, one-hot owner (bit i = input i), RR pointer.
    state_t     state_r [5];
    state_t     state_s [5];
    logic [4:0] grant_r [5];
    logic [4:0] grant_s [5];
    logic [2:0] ptr_r   [5];
    logic [2:0] ptr_s   [5];

    logic [4:0] req_s     [5];
    logic [4:0] eff_req_s [5];
    logic [4:0] want_s    [5];   // want_s[j][i]: input i bids for output j
    logic [4:0] sel_s     [5];   // sel_s[i][j]: transposed view of grant_r
    logic [4:0] fire_s;
    logic [4:0] owns_s;
    logic       found_s;
    logic [3:0] sum_s;
    logic [2:0] idx_s;

    // Isolate the lowest set bit so a malformed request can only ever name
    // a single output.
    function automatic logic [4:0] lowest_bit(input logic [4:0] v);
        return v & (~v + 5'd1);
    endfunction

    // Request decode: effective single-target requests, masked by ownership.
    always_comb begin
        req_s[0] = req_vc0;
        req_s[1] = req_vc1;
        req_s[2] = req_vc2;
        req_s[3] = req_vc3;
        req_s[4] = req_vc4;
        fire_s   = valid_in & xbar_ready;
        owns_s   = 5'd0;
        for (int j = 0; j < NUM_VC; j++) begin
            owns_s = owns_s | grant_r[j];
        end
        for (int i = 0; i < NUM_VC; i++) begin
            eff_req_s[i] = lowest_bit(req_s[i]);
        end
        // An input that already owns an output (even one releasing this
        // cycle) is excluded until the following cycle.
        for (int j = 0; j < NUM_VC; j++) begin
            want_s[j] = 5'd0;
            for (int i = 0; i < NUM_VC; i++) begin
                want_s[j][i] = valid_in[i] & eff_req_s[i][j] & ~owns_s[i];
            end
        end
    end

    // Next-state logic for the five per-output arbiter FSMs.
    always_comb begin
        found_s = 1'b0;
        sum_s   = 4'd0;
        idx_s   = 3'd0;
        for (int j = 0; j < NUM_VC; j++) begin
            state_s[j] = state_r[j];
            grant_s[j] = grant_r[j];
            ptr_s[j]   = ptr_r[j];
            found_s    = 1'b0;
            case (state_r[j])
                ST_IDLE: begin
                    // Scan ptr, ptr+1, ... modulo NUM_VC; first bidder wins.
                    for (int k = 0; k < NUM_VC; k++) begin
                        sum_s = {1'b0, ptr_r[j]} + 4'(k);
                        if (sum_s >= 4'(NUM_VC)) begin
                            sum_s = sum_s - 4'(NUM_VC);
                        end else begin
                            sum_s = sum_s;
                        end
                        idx_s = sum_s[2:0];
                        if (!found_s && want_s[j][idx_s]) begin
                            found_s           = 1'b1;
                            grant_s[j]        = 5'd0;
                            grant_s[j][idx_s] = 1'b1;
                            ptr_s[j]          = (idx_s == 3'(NUM_VC - 1)) ? 3'd0 : idx_s + 3'd1;
                            state_s[j]        = ST_LOCKED;
                        end else begin
                            found_s = found_s;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Release only when the owner's tail flit actually fires.
                    if (|(grant_r[j] & fire_s & tail_in)) begin
                        state_s[j] = ST_IDLE;
                        grant_s[j] = 5'd0;
                    end else begin
                        state_s[j] = ST_LOCKED;
                    end
                end
                default: begin
                    state_s[j] = ST_IDLE;
                    grant_s[j] = 5'd0;
                end
            endcase
        end
    end

    // Arbiter state registers; reset drops every lock immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < NUM_VC; j++) begin
                state_r[j] <= ST_IDLE;
                grant_r[j] <= 5'd0;
                ptr_r[j]   <= 3'(RR_INIT);
            end
        end else begin
            for (int j = 0; j < NUM_VC; j++) begin
                state_r[j] <= state_s[j];
                grant_r[j] <= grant_s[j];
                ptr_r[j]   <= ptr_s[j];
            end
        end
    end

    // Output view: pure rewiring of the owner registers, no input paths.
    always_comb begin
        out_locked = 5'd0;
        for (int i = 0; i < NUM_VC; i++) begin
            sel_s[i] = 5'd0;
        end
        for (int j = 0; j < NUM_VC; j++) begin
            out_locked[j] = (state_r[j] == ST_LOCKED);
            for (int i = 0; i < NUM_VC; i++) begin
                sel_s[i][j] = grant_r[j][i];
            end
        end
    end

    assign selVCfromVC0 = sel_s[0];
    assign selVCfromVC1 = sel_s[1];
    assign selVCfromVC2 = sel_s[2];
    assign selVCfromVC3 = sel_s[3];
    assign selVCfromVC4 = sel_s[4];

endmodule
